sm_mem_arbiter: RTL
===================

Name: sm_mem_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: port 0 (instruction fetch) and port 1 (data/debug loader).
- Sits between the CPU fetch path or loader and the memory macro, replacing the direct imAddr/imData connection.
- Arbitrates per cycle with a request/grant handshake and returns read data to the owning port after the fixed memory latency.
- Two arbitration policies: fixed priority with a starvation guard, or round-robin.

Parameters:
- AW, 32, address width for both ports and the memory side.
- DW, 32, data width.
- LAT, 1, memory read latency in cycles (legal 1..4).
- RR, 0, policy select: 0 = port 0 has fixed priority with starvation guard; 1 = round-robin.
- MAX_WAIT, 7, consecutive cycles port 1 may be refused before it is forced (RR=0 only, legal 1..15).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request valid.
- p0_addr  in  AW  port 0 address.
- p0_gnt  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DW  port 0 read data.
- p1_req  in  1  port 1 request valid.
- p1_we  in  1  port 1 write enable.
- p1_addr  in  AW  port 1 address.
- p1_wdata  in  DW  port 1 write data.
- p1_gnt  out  1  port 1 request accepted this cycle.
- p1_rvalid  out  1  port 1 read data valid (reads only).
- p1_rdata  out  DW  port 1 read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en with mem_we=0.

Behaviour:
- Port 0 is read-only.
- Grant is combinational from the current requests and the registered arbiter state.
- At most one of p0_gnt/p1_gnt is high per cycle, and gnt is only high when the matching req is high.
- A request is accepted in the cycle where req and gnt are both high. The requester holds req, addr and wdata stable until accepted.
- On accept: mem_en=1 in the same cycle, with mem_we/mem_addr/mem_wdata muxed from the granted port.
- With no grant: mem_en=0, mem_we=0; mem_addr and mem_wdata are don't-care.
- Throughput: one access per cycle with no bubbles.

Return pipeline:
- Shift register of LAT stages, each holding {valid, owner}. A stage is loaded valid only for granted reads; writes load valid=0.
- At stage LAT: pX_rvalid=1 for the owning port, and pX_rdata=mem_rdata for both ports (unqualified).
- Read data returns in issue order, exactly LAT cycles after accept.

RR=0 policy:
- Port 0 wins when both request.
- wait_cnt (4 bits) increments each cycle p1_req=1 and p1_gnt=0, saturating at 15.
- wait_cnt clears on a p1 accept or when p1_req=0.
- When wait_cnt >= MAX_WAIT, port 1 wins over port 0.

RR=1 policy:
- Registered last-owner bit; the port that did not win last has priority on a conflict.
- last-owner updates only on an accept.
- With a single requester, that requester is granted and last-owner updates.

Reset (rst=1):
- All pipeline valid bits=0, wait_cnt=0, last-owner=1 (so port 0 wins the first conflict).
- Outputs forced: gnt=0, rvalid=0, mem_en=0, mem_we=0. rdata is don't-care.
- Reset mid-transaction drops in-flight reads: no rvalid is ever produced for them. The memory write of the accept cycle itself is not undone.

Boundary conditions:
- Write followed by a read to the same address in back-to-back cycles: the read returns the new data. This relies on the memory's write-then-read ordering; the arbiter adds no forwarding.
- p1_req deasserted before grant: legal; no access issued, wait_cnt clears.

Decomposition:
- Shared package/include: owner encoding constants (OWN_P0=0, OWN_P1=1) and policy constants (ARB_FIXED=0, ARB_RR=1).
- One natural sub-module: sm_arb_retpipe, the LAT-deep {valid, owner} shift register with synchronous reset.
- The grant logic stays in the top module.

Test Plan:
- RR=0, LAT=1: p0 reads addr 4 every cycle, p1 idle -> p0_gnt=1 each cycle; p0_rvalid=1 one cycle later with mem[4]; mem_en never drops.
- RR=0, MAX_WAIT=7: p0 and p1 request continuously -> p1 refused 7 cycles, granted on the 8th; p0_gnt=0 that cycle; wait_cnt back to 0.
- RR=1: both request continuously -> grants alternate p0,p1,p0,...; the first conflict after reset goes to p0.
- LAT=3: p1 writes 0xDEADBEEF to 0x10, then p0 reads 0x10 the next cycle -> p0_rvalid exactly 3 cycles after accept with 0xDEADBEEF; no p1_rvalid for the write.
- rst asserted 1 cycle after two reads accepted (LAT=2) -> no rvalid ever seen for either read; after rst drops, the first conflict goes to p0.
- p1 raises req for 2 cycles while p0 holds the bus, then drops it (RR=0) -> no p1 access issued, wait_cnt=0, no p1_rvalid.

Source files
------------

// File: rtl/sm_mem_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// Owner and policy encodings plus the return-pipeline stage bundle.
package sm_mem_arbiter_pkg;

  localparam logic OWN_P0 = 1'b0;
  localparam logic OWN_P1 = 1'b1;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int WAIT_W = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } ret_t;

endpackage

// File: rtl/sm_arb_retpipe.sv
// Return pipeline for the memory arbiter.
// Carries {valid, owner} of each issued read LAT stages deep.
module sm_arb_retpipe
  import sm_mem_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  ret_t in_ret,
  output ret_t out_ret
);

  ret_t pipe_q [LAT];
  ret_t pipe_d [LAT];

  // shift the tag of each accepted access one stage per cycle
  always_comb begin
    pipe_d[0] = in_ret;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // stage registers; reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_ret = pipe_q[LAT-1];

endmodule

// File: rtl/sm_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Port 0 is a read-only fetch port, port 1 a read/write loader port.
module sm_mem_arbiter
  import sm_mem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LAT      = 1,
  parameter int RR       = 0,
  parameter int MAX_WAIT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              last_q, last_d;
  logic              p1_win;
  ret_t              ret_in, ret_out;

  // pick a winner from live requests and registered policy state
  always_comb begin
    p1_win = 1'b0;
    if (RR == ARB_RR) begin
      p1_win = p1_req &&
               (!p0_req || last_q == OWN_P0);
    end else begin
      p1_win = p1_req &&
               (!p0_req || wait_q >= WAIT_LIM);
    end
    p1_gnt = p1_win && !rst;
    p0_gnt = p0_req && !p1_win && !rst;
  end

  // steer the granted port onto the memory side
  always_comb begin
    mem_en    = p0_gnt || p1_gnt;
    mem_we    = p1_gnt && p1_we;
    mem_addr  = p1_gnt ? p1_addr : p0_addr;
    mem_wdata = p1_wdata;
  end

  // policy state: last owner and port 1 refusal count
  always_comb begin
    last_d = last_q;
    if (p0_gnt) begin
      last_d = OWN_P0;
    end else if (p1_gnt) begin
      last_d = OWN_P1;
    end
    wait_d = wait_q;
    if (!p1_req || p1_gnt) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // policy registers; port 0 wins the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      last_q <= OWN_P1;
    end else begin
      wait_q <= wait_d;
      last_q <= last_d;
    end
  end

  // tag each accept; writes travel as empty slots
  always_comb begin
    ret_in.valid = p0_gnt || (p1_gnt && !p1_we);
    ret_in.owner = p1_gnt ? OWN_P1 : OWN_P0;
  end

  sm_arb_retpipe #(
    .LAT (LAT)
  ) u_retpipe (
    .clk     (clk),
    .rst     (rst),
    .in_ret  (ret_in),
    .out_ret (ret_out)
  );

  // route returning data to the owner of the oldest read
  always_comb begin
    p0_rvalid = ret_out.valid && !rst &&
                ret_out.owner == OWN_P0;
    p1_rvalid = ret_out.valid && !rst &&
                ret_out.owner == OWN_P1;
    p0_rdata  = mem_rdata;
    p1_rdata  = mem_rdata;
  end

endmodule
